// File: rtl/neuron_sequencer.sv
// neuron_sequencer: per-timestep controller for one fully-connected spiking layer.
// Time-multiplexes a single combinational neuron stage over NUM_OUTPUTS neurons.
// For each neuron j it scans the latched input spikes and fetches w[j][i] for every
// set bit. It accumulates with saturation into a membrane register file, then runs
// one fire pass per neuron.
module neuron_sequencer #(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_OUTPUTS = 10,
    parameter int W_ADDR_W    = 8,
    localparam int IDX_W      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    start,
    input  logic [NUM_INPUTS-1:0]   in_spikes,
    input  logic                    vmem_clear,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_OUTPUTS-1:0]  out_spikes,
    output logic                    w_rd_en,
    output logic [W_ADDR_W-1:0]     w_addr,
    input  logic signed [7:0]       w_data,
    output logic signed [7:0]       n_weight,
    output logic signed [8:0]       n_v_mem_in,
    output logic                    n_function_sel,
    input  logic                    n_spike,
    input  logic signed [8:0]       n_v_mem_out,
    input  logic [IDX_W-1:0]        dbg_idx,
    output logic [8:0]              dbg_vmem
);

    localparam int I_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_ACCUM = 3'd2,
        S_FIRE  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [I_W-1:0]         i_q, i_d;
    logic [IDX_W-1:0]       j_q, j_d;
    logic [NUM_INPUTS-1:0]  spk_q, spk_d;
    logic [NUM_OUTPUTS-1:0] spike_acc_q, spike_acc_d;
    logic [NUM_OUTPUTS-1:0] out_spikes_q, out_spikes_d;
    logic [7:0]             vmem_q [NUM_OUTPUTS];

    logic                   vmem_we;
    logic                   vmem_clr;
    logic [7:0]             vmem_wdata;
    logic                   last_i;
    logic                   last_j;
    logic [W_ADDR_W-1:0]    scan_addr;

    // Saturating accumulate: decide on the true 10-bit sum so a wrapped 9-bit
    // neuron result can never leak into the 0..255 membrane range.
    function automatic logic [7:0] clamp_acc(input logic [7:0] v,
                                             input logic signed [7:0] w,
                                             input logic [7:0] nout);
        logic signed [9:0] sum;
        sum = $signed({2'b00, v}) + $signed({{2{w[7]}}, w});
        if (sum > 10'sd255)
            clamp_acc = 8'hFF;
        else if (sum < 10'sd0)
            clamp_acc = 8'h00;
        else
            clamp_acc = nout;
    endfunction

    // Fire write-back: a negative result would break the 0..255 invariant, floor it.
    function automatic logic [7:0] floor_fire(input logic signed [8:0] nout);
        floor_fire = nout[8] ? 8'h00 : nout[7:0];
    endfunction

    assign last_i     = (i_q == I_W'(NUM_INPUTS - 1));
    assign last_j     = (j_q == IDX_W'(NUM_OUTPUTS - 1));
    assign scan_addr  = W_ADDR_W'(int'(j_q) * NUM_INPUTS + int'(i_q));
    assign n_v_mem_in = $signed({1'b0, vmem_q[j_q]});
    assign out_spikes = out_spikes_q;

    // Debug read port; out-of-range indices read as zero.
    always_comb begin
        dbg_vmem = '0;
        if (int'(dbg_idx) < NUM_OUTPUTS)
            dbg_vmem = {1'b0, vmem_q[dbg_idx]};
    end

    // Next-state, datapath strobes and neuron control for the sequencer FSM.
    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        j_d            = j_q;
        spk_d          = spk_q;
        spike_acc_d    = spike_acc_q;
        out_spikes_d   = out_spikes_q;
        vmem_we        = 1'b0;
        vmem_clr       = 1'b0;
        vmem_wdata     = '0;
        w_rd_en        = 1'b0;
        w_addr         = '0;
        n_weight       = '0;
        n_function_sel = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                vmem_clr = vmem_clear;
                if (start) begin
                    spk_d   = in_spikes;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (spk_q[i_q]) begin
                    w_rd_en = 1'b1;
                    w_addr  = scan_addr;
                    state_d = S_ACCUM;
                end else if (last_i) begin
                    state_d = S_FIRE;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_ACCUM: begin
                n_weight   = w_data;
                vmem_we    = 1'b1;
                vmem_wdata = clamp_acc(vmem_q[j_q], w_data, n_v_mem_out[7:0]);
                if (last_i) begin
                    state_d = S_FIRE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_FIRE: begin
                n_function_sel   = 1'b1;
                vmem_we          = 1'b1;
                vmem_wdata       = floor_fire(n_v_mem_out);
                spike_acc_d[j_q] = n_spike;
                if (last_j) begin
                    // Publish now so the vector is already valid in the done cycle.
                    out_spikes_d = spike_acc_d;
                    state_d      = S_DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    i_d     = '0;
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, spike vectors and membrane register file.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            spk_q        <= '0;
            spike_acc_q  <= '0;
            out_spikes_q <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++)
                vmem_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            spk_q        <= spk_d;
            spike_acc_q  <= spike_acc_d;
            out_spikes_q <= out_spikes_d;
            for (int k = 0; k < NUM_OUTPUTS; k++)
                if (vmem_clr)
                    vmem_q[k] <= '0;
            if (vmem_we)
                vmem_q[j_q] <= vmem_wdata;
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench for neuron_sequencer: 4 inputs, 2 outputs, 1-cycle weight ROM and a
// behavioural neuron (accumulate, or fire with reset-to-zero at v >= vth).
module tb_neuron_sequencer;

    localparam int NI = 4;
    localparam int NO = 2;

    logic              clk = 1'b0;
    logic              wb_rst_i;
    logic              start;
    logic [NI-1:0]     in_spikes;
    logic              vmem_clear;
    logic              busy;
    logic              done;
    logic [NO-1:0]     out_spikes;
    logic              w_rd_en;
    logic [7:0]        w_addr;
    logic signed [7:0] w_data;
    logic signed [7:0] n_weight;
    logic signed [8:0] n_v_mem_in;
    logic              n_function_sel;
    logic              n_spike;
    logic signed [8:0] n_v_mem_out;
    logic [0:0]        dbg_idx;
    logic [8:0]        dbg_vmem;

    int checks   = 0;
    int failures = 0;
    int vth      = 5;

    logic signed [7:0] w_mem [0:NI*NO-1];
    int                addr_q [$];
    int                done_cnt = 0;
    int                busy_cnt = 0;

    int                mv [NO];
    logic [NO-1:0]     mspk;

    neuron_sequencer #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .W_ADDR_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start), .in_spikes(in_spikes),
        .vmem_clear(vmem_clear), .busy(busy), .done(done), .out_spikes(out_spikes),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data), .n_weight(n_weight),
        .n_v_mem_in(n_v_mem_in), .n_function_sel(n_function_sel), .n_spike(n_spike),
        .n_v_mem_out(n_v_mem_out), .dbg_idx(dbg_idx), .dbg_vmem(dbg_vmem)
    );

    always #5 clk = ~clk;

    // Weight ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (w_rd_en)
            w_data <= w_mem[w_addr[2:0]];
    end

    // Neuron: accumulate when function_sel=0, threshold/reset-to-zero when 1.
    always_comb begin
        if (n_function_sel) begin
            n_spike     = (int'(n_v_mem_in) >= vth);
            n_v_mem_out = n_spike ? 9'sd0 : n_v_mem_in;
        end else begin
            n_spike     = 1'b0;
            n_v_mem_out = n_v_mem_in + n_weight;
        end
    end

    // Monitor: record every weight fetch address and count done/busy cycles.
    always @(negedge clk) begin
        if (w_rd_en) addr_q.push_back(int'(w_addr));
        if (done) done_cnt <= done_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_vmem(input string tag);
        for (int j = 0; j < NO; j++) begin
            dbg_idx = 1'(j);
            #1;
            chk($sformatf("%s_vmem%0d", tag, j), 32'(dbg_vmem), 32'(mv[j]));
        end
    endtask

    // One timestep: reference model first, then drive the DUT and compare.
    task automatic run_ts(input string tag, input logic [NI-1:0] s, input bit clr, input bit ghost);
        int exp_addr [$];
        int v, k, pc, lat, base_a, base_d, base_b;
        bit got;
        if (clr) for (int j = 0; j < NO; j++) mv[j] = 0;
        pc = 0;
        for (int i = 0; i < NI; i++) if (s[i]) pc++;
        for (int j = 0; j < NO; j++) begin
            v = mv[j];
            for (int i = 0; i < NI; i++) begin
                if (s[i]) begin
                    exp_addr.push_back(j * NI + i);
                    v = v + int'(w_mem[j * NI + i]);
                    if (v > 255) v = 255;
                    if (v < 0) v = 0;
                end
            end
            mspk[j] = (v >= vth);
            if (mspk[j]) v = 0;
            mv[j] = v;
        end
        lat = 1 + NO * (NI + pc + 1);

        @(posedge clk); #1;
        start = 1'b1; in_spikes = s; vmem_clear = clr;
        base_a = addr_q.size(); base_d = done_cnt; base_b = busy_cnt;
        @(posedge clk); #1;
        start = 1'b0; vmem_clear = 1'b0; in_spikes = 4'($urandom);
        k = 1; got = 0;
        while (!got && k < 200) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                @(posedge clk); #1;
                k++;
                start      = ghost && (k == 3);
                vmem_clear = ghost && (k == 3);
                if (ghost && k == 3) in_spikes = ~s;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(k), 32'(lat));
        chk({tag, "_out_spikes"}, 32'(out_spikes), 32'(mspk));
        @(posedge clk); #1;
        start = 1'b0; vmem_clear = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_count"}, 32'(done_cnt - base_d), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt - base_b), 32'(lat));
        chk({tag, "_fetch_count"}, 32'(addr_q.size() - base_a), 32'(exp_addr.size()));
        for (int n = 0; n < exp_addr.size(); n++)
            if (base_a + n < addr_q.size())
                chk($sformatf("%s_addr%0d", tag, n), 32'(addr_q[base_a + n]), 32'(exp_addr[n]));
        check_vmem(tag);
    endtask

    task automatic rand_weights();
        for (int a = 0; a < NI * NO; a++) w_mem[a] = 8'($urandom);
    endtask

    initial begin
        int lim;
        wb_rst_i = 1'b1; start = 1'b0; in_spikes = '0; vmem_clear = 1'b0; dbg_idx = '0;
        for (int a = 0; a < NI * NO; a++) w_mem[a] = '0;
        for (int j = 0; j < NO; j++) mv[j] = 0;
        mspk = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); wb_rst_i = 1'b0;

        // Reset state after 5 idle cycles
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_w_rd_en", 32'(w_rd_en), 32'd0);
        chk("rst_out_spikes", 32'(out_spikes), 32'd0);
        check_vmem("rst");

        // Directed example: sparse spikes, neuron 0 fires
        vth = 5;
        w_mem = '{8'sd3, 8'sd9, 8'sd4, 8'sd9, 8'sd1, 8'sd9, 8'sd1, 8'sd9};
        run_ts("ex0101", 4'b0101, 1'b0, 1'b0);
        run_ts("ex0000", 4'b0000, 1'b0, 1'b0);

        // Negative weight floors at zero
        w_mem[4] = -8'sd5;
        run_ts("floor", 4'b0001, 1'b0, 1'b0);

        // Saturation at 255 with firing suppressed
        vth = 1000;
        for (int a = 0; a < NI * NO; a++) w_mem[a] = 8'sd100;
        run_ts("sat_pre", 4'b0011, 1'b1, 1'b0);
        for (int a = 0; a < NI * NO; a++) w_mem[a] = 8'sd120;
        run_ts("sat", 4'b0111, 1'b0, 1'b0);

        // start and vmem_clear pulsed mid-timestep are ignored
        vth = 5;
        rand_weights();
        run_ts("ghost", 4'($urandom), 1'b0, 1'b1);

        // vmem_clear in IDLE zeroes all membranes
        vth = 1000;
        for (int a = 0; a < NI * NO; a++) w_mem[a] = 8'sd50;
        run_ts("pre_clr", 4'b1010, 1'b0, 1'b0);
        @(posedge clk); #1; vmem_clear = 1'b1;
        @(posedge clk); #1; vmem_clear = 1'b0;
        for (int j = 0; j < NO; j++) mv[j] = 0;
        check_vmem("idle_clear");

        // Randomized timesteps
        for (int r = 0; r < 10; r++) begin
            rand_weights();
            vth = int'($urandom_range(1, 300));
            run_ts($sformatf("rnd%0d", r), 4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset mid-ACCUM
        vth = 5;
        rand_weights();
        @(posedge clk); #1; start = 1'b1; in_spikes = 4'b1111;
        @(posedge clk); #1; start = 1'b0;
        lim = 0;
        while (!w_rd_en && lim < 40) begin
            @(negedge clk);
            lim++;
        end
        chk("arst_fetch_seen", 32'(w_rd_en), 32'd1);
        @(posedge clk); #2;
        wb_rst_i = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_w_rd_en", 32'(w_rd_en), 32'd0);
        chk("arst_w_addr", 32'(w_addr), 32'd0);
        chk("arst_fsel", 32'(n_function_sel), 32'd0);
        chk("arst_weight", 32'(n_weight), 32'd0);
        chk("arst_out_spikes", 32'(out_spikes), 32'd0);
        for (int j = 0; j < NO; j++) mv[j] = 0;
        mspk = '0;
        check_vmem("arst");
        @(negedge clk); wb_rst_i = 1'b0;
        run_ts("post_rst", 4'($urandom), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
